// File: rtl/keccak_absorb_loader.sv
// rtl/keccak_absorb_loader.sv - packs message words into Keccak rate lanes and absorbs them into the state
// The state is A[y][x] with lane i = 5*y + x, so lane i occupies bits [64*i +: 64].

package keccak_pkg;
  typedef logic [4:0][4:0][63:0] state_t;
endpackage

module keccak_absorb_loader
  import keccak_pkg::*;
#(
  parameter int W          = 64,
  parameter int RATE_LANES = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         first,
  input  state_t       st_in,
  output logic         blk_valid,
  input  logic         blk_ready,
  output state_t       blk_state
);

  localparam int WPL       = 64 / W;
  localparam int BLK_WORDS = RATE_LANES * WPL;
  localparam int CW        = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam int BUF_W     = RATE_LANES * 64;
  localparam logic [CW-1:0] LAST_WORD = CW'(BLK_WORDS - 1);

  typedef enum logic {S_FILL, S_HOLD} state_e;

  state_e           r_state;
  logic [CW-1:0]    r_word_cnt;
  logic [BUF_W-1:0] r_buf;
  logic             r_first_q;
  logic             r_in_ready;
  logic             r_blk_valid;

  state_t           w_mixed;
  logic             w_accept;
  int               w_bit_base;

  assign w_accept   = in_valid & r_in_ready;
  // Word k lands at bit k*W of the flattened rate, which is lane k/WPL, offset (k%WPL)*W.
  assign w_bit_base = int'(r_word_cnt) * W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_word_cnt  <= '0;
      r_buf       <= '0;
      r_first_q   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_blk_valid <= 1'b0;
    end else if (clr) begin
      r_state     <= S_FILL;
      r_word_cnt  <= '0;
      r_buf       <= '0;
      r_in_ready  <= 1'b1;
      r_blk_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_buf[w_bit_base +: W] <= in_data;
            if (r_word_cnt == '0) begin
              r_first_q <= first;
            end
            if (r_word_cnt == LAST_WORD) begin
              r_word_cnt  <= '0;
              r_state     <= S_HOLD;
              r_in_ready  <= 1'b0;
              r_blk_valid <= 1'b1;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (blk_ready) begin
            r_buf       <= '0;
            r_state     <= S_FILL;
            r_in_ready  <= 1'b1;
            r_blk_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 25; gi++) begin : g_lane
    if (gi < RATE_LANES) begin : g_rate
      assign w_mixed[gi/5][gi%5] = r_first_q ? r_buf[gi*64 +: 64]
                                             : (st_in[gi/5][gi%5] ^ r_buf[gi*64 +: 64]);
    end else begin : g_cap
      assign w_mixed[gi/5][gi%5] = r_first_q ? 64'd0 : st_in[gi/5][gi%5];
    end
  end

  assign blk_state = (r_state == S_HOLD) ? w_mixed : '0;
  assign in_ready  = r_in_ready;
  assign blk_valid = r_blk_valid;

endmodule
